// File: rtl/deskew_pkg.sv
// Shared constants and FSM state type for the multi-lane PCS receive deskew.
package deskew_pkg;

    localparam int unsigned DEF_BLOCK_W          = 66;
    localparam int unsigned DEF_MAX_SKEW_BIT_N   = 1856;
    localparam int unsigned DEF_MAX_SKEW_BLOCK_N =
        (DEF_MAX_SKEW_BIT_N - DEF_BLOCK_W - 1) / DEF_BLOCK_W;

    function automatic int unsigned skew_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DEF_SKEW_CNT_W = skew_cnt_w(DEF_MAX_SKEW_BLOCK_N);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_MEASURE,
        ST_LOCKED
    } state_e;

endpackage

// File: rtl/deskew_buf.sv
// Per-lane stall-enabled delay line of {AM flag, block}; skew selects the tap,
// skew 0 bypasses straight from the input.
module deskew_buf #(
    parameter int unsigned BLOCK_W    = 66,
    parameter int unsigned DEPTH      = 27,
    parameter int unsigned SKEW_CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  shift_i,
    input  logic [BLOCK_W-1:0]    data_i,
    input  logic                  am_i,
    input  logic [SKEW_CNT_W-1:0] skew_i,
    output logic [BLOCK_W-1:0]    data_o,
    output logic                  am_o
);

    logic [BLOCK_W:0] mem_q [DEPTH];
    logic [BLOCK_W:0] rd;

    always_ff @(posedge clk) begin
        if (shift_i) begin
            mem_q[0] <= {am_i, data_i};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    // Tap k holds the block presented k valid cycles ago.
    always_comb begin
        rd = {am_i, data_i};
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            if (skew_i == SKEW_CNT_W'(i)) begin
                rd = mem_q[i-1];
            end
        end
    end

    assign {am_o, data_o} = rd;

endmodule

// File: rtl/deskew_rx.sv
// Multi-lane receive deskew: measures AM arrival skew, aligns all lanes on the
// latest lane and strips aligned AMs from the valid-qualified output.
module deskew_rx
    import deskew_pkg::*;
#(
    parameter int unsigned LANE_N           = 4,
    parameter int unsigned BLOCK_W          = DEF_BLOCK_W,
    parameter int unsigned MAX_SKEW_BIT_N   = DEF_MAX_SKEW_BIT_N,
    parameter int unsigned MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W,
    parameter int unsigned SKEW_CNT_W       = skew_cnt_w(MAX_SKEW_BLOCK_N),
    parameter bit          AM_DROP          = 1'b1
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         lane_v_i,
    input  logic                         am_lock_i,
    input  logic [LANE_N-1:0]            am_v_i,
    input  logic [LANE_N*BLOCK_W-1:0]    data_i,
    output logic [LANE_N*BLOCK_W-1:0]    data_o,
    output logic                         data_v_o,
    output logic                         deskew_lock_o,
    output logic                         skew_err_o,
    output logic [LANE_N*SKEW_CNT_W-1:0] skew_o
);

    state_e                    state_q;
    logic [LANE_N-1:0]         seen_q;
    logic [SKEW_CNT_W-1:0]     skew_q [LANE_N];
    logic [LANE_N*BLOCK_W-1:0] data_q;
    logic                      data_v_q;
    logic                      lock_q;
    logic                      err_q;

    logic [LANE_N*BLOCK_W-1:0] rd_data;
    logic [LANE_N-1:0]         rd_am;
    logic [LANE_N-1:0]         seen_d;
    logic                      ovf_d;

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        deskew_buf #(
            .BLOCK_W    (BLOCK_W),
            .DEPTH      (MAX_SKEW_BLOCK_N),
            .SKEW_CNT_W (SKEW_CNT_W)
        ) u_buf (
            .clk     (clk),
            .shift_i (lane_v_i),
            .data_i  (data_i[l*BLOCK_W +: BLOCK_W]),
            .am_i    (am_v_i[l]),
            .skew_i  (skew_q[l]),
            .data_o  (rd_data[l*BLOCK_W +: BLOCK_W]),
            .am_o    (rd_am[l])
        );
    end

    always_comb begin
        seen_d = seen_q | am_v_i;
        ovf_d  = 1'b0;
        for (int unsigned l = 0; l < LANE_N; l++) begin
            if (seen_q[l] && !am_v_i[l] &&
                skew_q[l] == SKEW_CNT_W'(MAX_SKEW_BLOCK_N - 1)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_WAIT;
            seen_q   <= '0;
            data_q   <= '0;
            data_v_q <= 1'b0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int unsigned l = 0; l < LANE_N; l++) skew_q[l] <= '0;
        end else begin
            err_q    <= 1'b0;
            data_v_q <= 1'b0;
            if (!am_lock_i) begin
                state_q <= ST_WAIT;
                seen_q  <= '0;
                lock_q  <= 1'b0;
                for (int unsigned l = 0; l < LANE_N; l++) skew_q[l] <= '0;
            end else if (lane_v_i) begin
                case (state_q)
                    ST_WAIT: begin
                        if (|am_v_i) begin
                            seen_q <= am_v_i;
                            if (&am_v_i) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end else begin
                                state_q <= ST_MEASURE;
                            end
                        end
                    end
                    ST_MEASURE: begin
                        if (ovf_d || |(seen_q & am_v_i)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT;
                            seen_q  <= '0;
                            for (int unsigned l = 0; l < LANE_N; l++) skew_q[l] <= '0;
                        end else begin
                            seen_q <= seen_d;
                            for (int unsigned l = 0; l < LANE_N; l++) begin
                                if (am_v_i[l])      skew_q[l] <= '0;
                                else if (seen_q[l]) skew_q[l] <= skew_q[l] + 1'b1;
                            end
                            if (&seen_d) begin
                                state_q <= ST_LOCKED;
                                lock_q  <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // A partial aligned AM means the measured skew no longer holds.
                        if (|rd_am && !(&rd_am)) begin
                            err_q   <= 1'b1;
                            lock_q  <= 1'b0;
                            state_q <= ST_WAIT;
                            seen_q  <= '0;
                            for (int unsigned l = 0; l < LANE_N; l++) skew_q[l] <= '0;
                        end else begin
                            data_q   <= rd_data;
                            data_v_q <= !(AM_DROP && (&rd_am));
                        end
                    end
                    default: state_q <= ST_WAIT;
                endcase
            end
        end
    end

    always_comb begin
        skew_o = '0;
        for (int unsigned l = 0; l < LANE_N; l++) begin
            skew_o[l*SKEW_CNT_W +: SKEW_CNT_W] = skew_q[l];
        end
    end

    assign data_o        = data_q;
    assign data_v_o      = data_v_q;
    assign deskew_lock_o = lock_q;
    assign skew_err_o    = err_q;

endmodule

// File: tb/tb_deskew_rx.sv
// Directed bench for deskew_rx: table-driven zero-skew/lock-loss/misalignment
// vectors plus hand sequences for staggered AMs, stalls, overflow and reset.
module tb_deskew_rx;

    localparam int unsigned LANE_N = 4;
    localparam int unsigned BW     = 66;
    localparam int unsigned SW     = 5;
    localparam int unsigned DW     = LANE_N * BW;

    logic              clk = 1'b0;
    logic              nreset;
    logic              lane_v_i;
    logic              am_lock_i;
    logic [LANE_N-1:0] am_v_i;
    logic [DW-1:0]     data_i;
    logic [DW-1:0]     data_o;
    logic              data_v_o;
    logic              deskew_lock_o;
    logic              skew_err_o;
    logic [LANE_N*SW-1:0] skew_o;

    always #5 clk = ~clk;

    deskew_rx #(.LANE_N(LANE_N)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .lane_v_i      (lane_v_i),
        .am_lock_i     (am_lock_i),
        .am_v_i        (am_v_i),
        .data_i        (data_i),
        .data_o        (data_o),
        .data_v_o      (data_v_o),
        .deskew_lock_o (deskew_lock_o),
        .skew_err_o    (skew_err_o),
        .skew_o        (skew_o)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] tag [LANE_N];
    int unsigned ref_lane = 0;
    logic [15:0] ref_tag;

    typedef struct packed {
        logic       lv;
        logic       lk;
        logic [3:0] am;
        logic       ev;
        logic       el;
        logic       ee;
    } vec_t;

    vec_t tbl [14];

    // Block encodes lane id and sequence tag (0 = AM block of that lane).
    function automatic logic [BW-1:0] mk(input int unsigned l, input logic [15:0] t);
        logic [31:0] h;
        h = {t, t} ^ (32'h1234_5678 + 32'(l));
        return {2'b10, 16'(16'hA500 + l), t, h};
    endfunction

    task automatic chk_b(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic lv, input logic lk, input logic [3:0] am,
                       input logic ev, input logic el, input logic ee, input string nm);
        logic [15:0]   t;
        logic [DW-1:0] exp;
        lane_v_i  = lv;
        am_lock_i = lk;
        am_v_i    = am;
        for (int unsigned l = 0; l < LANE_N; l++) begin
            t = (lv && am[l]) ? 16'd0 : tag[l];
            data_i[l*BW +: BW] = mk(l, t);
            if (l == ref_lane) ref_tag = t;
            if (lv) tag[l] = t + 16'd1;
        end
        @(posedge clk);
        #1;
        chk_b({nm, " data_v"}, data_v_o, ev);
        chk_b({nm, " lock"}, deskew_lock_o, el);
        chk_b({nm, " err"}, skew_err_o, ee);
        if (ev) begin
            for (int unsigned l = 0; l < LANE_N; l++) exp[l*BW +: BW] = mk(l, ref_tag);
            chk_w({nm, " data"}, data_o, exp);
        end
    endtask

    task automatic stagger(input bit stalls, input string nm);
        int unsigned v = 0;
        int unsigned c = 0;
        logic [3:0]  am;
        ref_lane = 1;
        while (v <= 9) begin
            if (stalls && (c == 4 || c == 7)) begin
                cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, {nm, " meas stall"});
            end else begin
                am = (v == 0) ? 4'b0100 : (v == 3) ? 4'b0001 :
                     (v == 5) ? 4'b1000 : (v == 9) ? 4'b0010 : 4'b0000;
                cyc(1'b1, 1'b1, am, 1'b0, (v == 9), 1'b0, {nm, " meas"});
                if (v == 5) chk_w({nm, " live skew"}, DW'(skew_o), DW'({5'd0, 5'd5, 5'd0, 5'd2}));
                v++;
            end
            c++;
        end
        chk_w({nm, " skew"}, DW'(skew_o), DW'({5'd4, 5'd9, 5'd0, 5'd6}));
        for (int j = 0; j < 10; j++) begin
            if (stalls && j == 4) cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, {nm, " lock stall"});
            else                  cyc(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, {nm, " aligned"});
        end
    endtask

    initial begin
        //              lv    lk    am       ev    el    ee
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0};

        for (int unsigned l = 0; l < LANE_N; l++) tag[l] = 16'd0;
        nreset    = 1'b0;
        lane_v_i  = 1'b0;
        am_lock_i = 1'b0;
        am_v_i    = '0;
        data_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_b("rst data_v", data_v_o, 1'b0);
        chk_b("rst lock", deskew_lock_o, 1'b0);
        chk_b("rst err", skew_err_o, 1'b0);
        chk_w("rst skew", DW'(skew_o), '0);
        chk_w("rst data", data_o, '0);
        @(negedge clk);
        nreset = 1'b1;

        ref_lane = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].lv, tbl[i].lk, tbl[i].am, tbl[i].ev, tbl[i].el, tbl[i].ee,
                $sformatf("zs%0d", i));
            if (i == 1) chk_w("zero skew", DW'(skew_o), '0);
        end

        stagger(1'b0, "stag");
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "unlock1");
        stagger(1'b1, "stall");
        cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "unlock2");

        cyc(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, "ovf am");
        for (int k = 1; k <= 27; k++) begin
            cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, (k == 27), "ovf");
            if (k == 26) chk_w("ovf max skew", DW'(skew_o), DW'(20'd26));
        end
        cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "ovf after");
        chk_w("ovf cleared", DW'(skew_o), '0);

        cyc(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, "rep am");
        cyc(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, "rep again");
        cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "rep after");

        cyc(1'b1, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, "rst meas");
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, "rst meas");
        chk_w("pre-reset skew", DW'(skew_o), DW'({5'd0, 5'd3, 5'd0, 5'd0}));
        #2 nreset = 1'b0;
        #1;
        chk_w("async rst skew", DW'(skew_o), '0);
        chk_w("async rst data", data_o, '0);
        chk_b("async rst data_v", data_v_o, 1'b0);
        chk_b("async rst lock", deskew_lock_o, 1'b0);
        chk_b("async rst err", skew_err_o, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        ref_lane = 0;
        cyc(1'b1, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, "post-rst lock");
        cyc(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, "post-rst data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/deskew_rx.md
Name: deskew_rx

Overview:
- Multi-lane receive deskew for the 40G/100G PCS.
- Sits after per-lane alignment-marker (AM) lock and lane reorder, before descrambling.
- Measures the relative skew of LANE_N lanes from per-lane AM arrival, buffers each lane by its skew so all lanes align on the latest lane, and removes AMs from the output stream.
- Adds over a single-lane deskew buffer: gearbox-stall handling, lock/relock FSM, skew-overflow and AM-misalignment error detection, and a registered, valid-qualified output.

Parameters:
- LANE_N, 4, number of PCS lanes.
- BLOCK_W, 66, block width in bits.
- MAX_SKEW_BIT_N, 1856, max dynamic skew in bits.
- MAX_SKEW_BLOCK_N, (MAX_SKEW_BIT_N-BLOCK_W-1)/BLOCK_W (=27), buffer depth per lane in blocks.
- SKEW_CNT_W, $clog2(MAX_SKEW_BLOCK_N+1), skew counter width.
- AM_DROP, 1, 1: suppress data_v_o on aligned AM cycles; 0: pass AMs through.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- lane_v_i  in  1  blocks valid on all lanes this cycle; 0 = gearbox slip, lanes stall.
- am_lock_i  in  1  every lane has individual AM lock.
- am_v_i  in  LANE_N  per-lane AM block present this cycle; qualified by lane_v_i.
- data_i  in  LANE_N*BLOCK_W  lane blocks, lane 0 in LSBs.
- data_o  out  LANE_N*BLOCK_W  deskewed blocks.
- data_v_o  out  1  data_o valid.
- deskew_lock_o  out  1  lanes aligned.
- skew_err_o  out  1  one-cycle pulse on skew overflow or AM misalignment.
- skew_o  out  LANE_N*SKEW_CNT_W  measured skew per lane; debug only.

Behaviour:
- Reset (async assert, sync deassert in clk domain):
  - FSM=WAIT.
  - All skew counters 0, seen flags 0.
  - data_o=0, data_v_o=0, deskew_lock_o=0, skew_err_o=0, skew_o=0.
  - Buffer contents are don't-care.
- Stall: when lane_v_i=0, buffers do not shift, counters hold, data_v_o=0 next cycle. am_v_i is ignored on that cycle.
- Per-lane buffer: shifts in data_i and am_v_i on each lane_v_i=1. Read pointer = lane skew; skew 0 reads data_i directly.
- Output timing: data_o and aligned AM flags are registered. Latency is 1 cycle after the latest lane's block is presented.
- FSM states, evaluated on lane_v_i=1 cycles unless stated:
  - WAIT:
    - Counters held at 0.
    - When am_lock_i=1 and any am_v_i bit is set: go to MEASURE. Lanes with am_v_i set get their seen flag set, counter 0.
    - If all bits are set on that cycle, go directly to LOCKED with all skews 0.
  - MEASURE:
    - Counters of seen lanes increment by 1 per valid cycle.
    - A lane whose am_v_i arrives sets seen; its counter resets to 0 that cycle.
    - All lanes seen: go to LOCKED, counters frozen.
    - Overflow (any counter would exceed MAX_SKEW_BLOCK_N-1): pulse skew_err_o and return to WAIT.
    - Repeat AM on an already-seen lane: pulse skew_err_o and return to WAIT.
  - LOCKED:
    - deskew_lock_o=1 from the cycle after entry.
    - data_v_o follows the registered lane_v_i.
    - Any aligned AM flag set while the others are clear: pulse skew_err_o and go to WAIT.
    - Aligned AM on all lanes with AM_DROP=1: data_v_o=0 for that block.
- Exit conditions:
  - am_lock_i=0 in any state: go to WAIT next cycle, regardless of lane_v_i. deskew_lock_o and data_v_o fall at that same edge.
  - Error exit: skew_err_o asserts for exactly 1 cycle, coincident with deskew_lock_o falling.
- Resulting skew: the latest lane ends at skew 0. The earliest lane ends at skew = arrival difference in valid cycles; counters do not advance over stalls.
- Outside LOCKED: data_v_o=0 and data_o is don't-care. data_o is never forwarded unlocked.
- skew_o reflects the live counters in MEASURE and the frozen values in LOCKED.

Decomposition:
- Package deskew_pkg:
  - typedef for the FSM state enum (WAIT, MEASURE, LOCKED).
  - BLOCK_W and default MAX_SKEW_BLOCK_N constants.
  - SKEW_CNT_W derivation.
- Sub-module deskew_buf, instanced per lane:
  - Stall-enabled shift buffer of BLOCK_W+1 bits (data plus AM flag), depth MAX_SKEW_BLOCK_N.
  - Skew-indexed read mux.
- Top level holds the FSM, the skew counters and the output registers.

Test Plan:
- Zero skew: all four am_v_i set together with am_lock_i=1. Required: LOCKED next cycle, skew_o all 0, data_o equals data_i delayed 1 cycle, AM block dropped from data_v_o.
- Staggered AMs at lanes 2,0,3,1 on cycles 0,3,5,9. Required: skew_o = lane0 6, lane1 0, lane2 9, lane3 4; output blocks of all lanes carry the same sequence tag; deskew_lock_o=1.
- Stalls: same pattern as the staggered test, with lane_v_i=0 on cycles 4 and 7. Required: identical skews; data_v_o low one cycle after each stall.
- Overflow: lane 0 AM, then no other AM for 27 valid cycles. Required: skew_err_o one-cycle pulse, FSM back in WAIT, deskew_lock_o stays 0.
- Lock loss: while LOCKED, drop am_lock_i for one cycle. Required: deskew_lock_o and data_v_o fall next edge, no skew_err_o; relocks on the next AM set.
- Misalignment and reset: while LOCKED, inject an AM one block early on lane 3. Required: skew_err_o pulse, unlock. Then assert nreset mid-MEASURE; required: all outputs 0 asynchronously.
